regfile_sb: RTL



---
 rtl/mznm_pkg.sv | 13 +
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_sb_pend_counter.sv | 31 +++
 rtl/regfile_sb.sv | 102 ++++++++++
 4 files changed

// File: rtl/mznm_pkg.sv
// Shared definitions for the MZNM core register file slice.
// Supplies default sizing, the architectural zero-register index and the
// register address type used by decode/issue logic.
package mznm_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);
  localparam int unsigned REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write-back port, issue reservation
// handshake, flush and the busy vector.
//   master : pipeline side (drives addresses, write-back, reservations)
//   slave  : register file side (returns read data, busy flags, ready)
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     res_valid;
  logic [ADDR_W-1:0]        res_addr;
  logic                     res_ready;
  logic                     flush;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, res_valid, res_addr, flush,
    input  rd_data, rd_busy, res_ready, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, res_valid, res_addr, flush,
    output rd_data, rd_busy, res_ready, busy_vec
  );

endinterface

// File: rtl/regfile_sb_pend_counter.sv
// pend_counter: per-register count of outstanding writes.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (flush), dominates inc/dec
//   inc      : a reservation was accepted for this register
//   dec      : a write-back hit this register
//   cnt      : current count
// inc and dec together leave the count unchanged. Decrement floors at zero,
// increment saturates at all-ones (the ready logic upstream should already
// prevent overflow).
module pend_counter #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with pending-write scoreboard.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_sb_if.slave
//     rd_addr/rd_data/rd_busy : NUM_RD asynchronous read ports with
//                               same-cycle write-back bypass and hazard flag
//     wr_en/wr_addr/wr_data   : synchronous write-back port (releases a
//                               pending reservation)
//     res_valid/res_addr/res_ready : destination reservation handshake
//     flush                   : clear all pending counters
//     busy_vec                : registered per-register pending flags
module regfile_sb
  import mznm_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned PEND_W   = 2,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] cnt  [DEPTH];

  logic wr_drop;
  logic res_zero;
  logic res_fire;

  assign wr_drop  = ZERO_REG && (bus.wr_addr == ZADDR);
  assign res_zero = ZERO_REG && (bus.res_addr == ZADDR);

  // A write landing on a saturated register frees a slot in the same cycle,
  // so the reservation may be taken and the counter nets to unchanged.
  assign bus.res_ready = res_zero
                      || (cnt[bus.res_addr] != '1)
                      || (bus.wr_en && (bus.wr_addr == bus.res_addr));
  assign res_fire = bus.res_valid && bus.res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wr_en && !wr_drop) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
    logic inc;
    logic dec;

    assign inc = res_fire && (bus.res_addr == IDX) && !(ZERO_REG && (IDX == ZADDR));
    assign dec = bus.wr_en && (bus.wr_addr == IDX);

    pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (inc),
      .dec (dec),
      .cnt (cnt[g])
    );
  end

  always_comb begin
    bus.busy_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bus.busy_vec[i] = |cnt[i];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              wr_hit;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    a           = '0;
    wr_hit      = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a      = bus.rd_addr[k*ADDR_W +: ADDR_W];
      wr_hit = bus.wr_en && (bus.wr_addr == a);
      if (ZERO_REG && (a == ZADDR)) begin
        bus.rd_data[k*DATA_W +: DATA_W] = '0;
        bus.rd_busy[k]                  = 1'b0;
      end else begin
        bus.rd_data[k*DATA_W +: DATA_W] = wr_hit ? bus.wr_data : regs[a];
        // The final outstanding write arriving now is forwarded through the
        // bypass, so only a count of one without a matching write still blocks.
        bus.rd_busy[k] = (cnt[a] > PEND_W'(1)) || ((cnt[a] == PEND_W'(1)) && !wr_hit);
      end
    end
  end

endmodule
